// File: rtl/acq_sequencer.sv
// Acquisition sequencer: waits for a stable clklock, latches the capture configuration and divides clk into sample strobes.
// Optional build macro ACQ_SAMPLE_LIMIT_EN adds a sample_limit port that ends capture after N strobes.
module acq_sequencer #(
    parameter int LOCK_STABLE   = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        acq_enable,
    input  logic [7:0]  clock_divisor,
    input  logic [15:0] channel_enable,
    input  logic        clklock,
    input  logic        fifo_overflow,
`ifdef ACQ_SAMPLE_LIMIT_EN
    input  logic [31:0] sample_limit,
`endif
    output logic        sample_strobe,
    output logic        capture_active,
    output logic [15:0] active_channels,
    output logic [2:0]  state,
    output logic        overflow_flag,
    output logic        lock_lost_flag,
    output logic        done_flag
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RUN       = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam int LW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_STABLE - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t        state_q, state_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [7:0]    per_cnt_q, per_cnt_d;
    logic [7:0]    div_q, div_d;
    logic [15:0]   chan_q, chan_d;
    logic          strobe_q, strobe_d;
    logic          active_q, active_d;
    logic          ovf_q, ovf_d;
    logic          lost_q, lost_d;
`ifdef ACQ_SAMPLE_LIMIT_EN
    logic [31:0]   samp_cnt_q, samp_cnt_d;
    logic          done_q, done_d;

    function automatic logic [31:0] sat_inc32(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction
`endif

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        settle_cnt_d = settle_cnt_q;
        per_cnt_d    = per_cnt_q;
        div_d        = div_q;
        chan_d       = chan_q;
        strobe_d     = 1'b0;
        ovf_d        = ovf_q;
        lost_d       = lost_q;
`ifdef ACQ_SAMPLE_LIMIT_EN
        samp_cnt_d   = samp_cnt_q;
        done_d       = done_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (acq_enable && (channel_enable != 16'd0)) begin
                    state_d    = S_WAIT_LOCK;
                    lock_cnt_d = '0;
                    ovf_d      = 1'b0;
                    lost_d     = 1'b0;
`ifdef ACQ_SAMPLE_LIMIT_EN
                    done_d     = 1'b0;
`endif
                end
            end
            S_WAIT_LOCK: begin
                if (!clklock) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = '0;
                    chan_d       = channel_enable;
                    div_d        = clock_divisor;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (!clklock) begin
                    state_d = S_HALT;
                    lost_d  = 1'b1;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    // First RUN cycle always carries a strobe.
                    state_d   = S_RUN;
                    per_cnt_d = 8'd0;
                    strobe_d  = 1'b1;
`ifdef ACQ_SAMPLE_LIMIT_EN
                    samp_cnt_d = 32'd1;
`endif
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (fifo_overflow) ovf_d = 1'b1;
                if (!clklock) lost_d = 1'b1;
                if (fifo_overflow || !clklock) begin
                    state_d = S_HALT;
                end
`ifdef ACQ_SAMPLE_LIMIT_EN
                else if ((sample_limit != 32'd0) && (samp_cnt_q >= sample_limit)) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end
`endif
                else if (per_cnt_q == div_q) begin
                    per_cnt_d = 8'd0;
                    strobe_d  = 1'b1;
`ifdef ACQ_SAMPLE_LIMIT_EN
                    samp_cnt_d = sat_inc32(samp_cnt_q);
`endif
                end else begin
                    per_cnt_d = per_cnt_q + 8'd1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Stop wins over every other transition; flags above are still recorded.
        if (!acq_enable && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            strobe_d = 1'b0;
        end
        active_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lock_cnt_q   <= '0;
            settle_cnt_q <= '0;
            per_cnt_q    <= 8'd0;
            div_q        <= 8'd0;
            chan_q       <= 16'd0;
            strobe_q     <= 1'b0;
            active_q     <= 1'b0;
            ovf_q        <= 1'b0;
            lost_q       <= 1'b0;
`ifdef ACQ_SAMPLE_LIMIT_EN
            samp_cnt_q   <= 32'd0;
            done_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            per_cnt_q    <= per_cnt_d;
            div_q        <= div_d;
            chan_q       <= chan_d;
            strobe_q     <= strobe_d;
            active_q     <= active_d;
            ovf_q        <= ovf_d;
            lost_q       <= lost_d;
`ifdef ACQ_SAMPLE_LIMIT_EN
            samp_cnt_q   <= samp_cnt_d;
            done_q       <= done_d;
`endif
        end
    end

    assign sample_strobe   = strobe_q;
    assign capture_active  = active_q;
    assign active_channels = chan_q;
    assign state           = state_q;
    assign overflow_flag   = ovf_q;
    assign lock_lost_flag  = lost_q;
`ifdef ACQ_SAMPLE_LIMIT_EN
    assign done_flag       = done_q;
`else
    assign done_flag       = 1'b0;
`endif

endmodule

// File: doc/acq_sequencer.md
# acq_sequencer

Acquisition sequencer between the register-file control outputs (acq_enable, clock_divisor, channel_enable) and the sampling/FIFO datapath. It waits for a stable sample-clock lock, latches configuration at start of capture, and generates the divided sample strobe. It halts capture on FIFO overflow or lock loss and reports sticky status back to the status register. Runs entirely in the normal clock domain.

## Interface
- LOCK_STABLE, default 16: consecutive cycles clklock must be high before capture proceeds (≥1).
- SETTLE_CYCLES, default 4: cycles between configuration latch and first sample (≥1).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- acq_enable  in  1  level; capture requested while high.
- clock_divisor  in  8  sample period minus one, in clk cycles.
- channel_enable  in  16  requested channel mask.
- clklock  in  1  sample clock PLL lock indication.
- fifo_overflow  in  1  level from FIFO; any high cycle in RUN is an overflow.
- sample_strobe  out  1  one-cycle pulse per sample.
- capture_active  out  1  high exactly while in RUN.
- active_channels  out  16  channel mask latched at entry to SETTLE.
- state  out  3  encoded state, for debug/status readback.
- overflow_flag  out  1  sticky; FIFO overflowed during RUN.
- lock_lost_flag  out  1  sticky; clklock dropped during RUN or SETTLE.
- done_flag  out  1  sticky; sample limit reached (0 unless ACQ_SAMPLE_LIMIT_EN).

## Operation
- States: IDLE=0, WAIT_LOCK=1, SETTLE=2, RUN=3, HALT=4. Other encodings go to IDLE next cycle.
- IDLE: acq_enable=1 and channel_enable≠0 → WAIT_LOCK; clears all three sticky flags on that transition. acq_enable=1 with mask 0 stays IDLE.
- WAIT_LOCK: lock counter increments while clklock=1, clears to 0 when clklock=0. Counter reaching LOCK_STABLE → SETTLE, latching channel_enable into active_channels and clock_divisor into an internal divisor register.
- SETTLE: counts SETTLE_CYCLES cycles → RUN. clklock=0 → HALT, lock_lost_flag set.
- RUN: 8-bit period counter; sample_strobe on first RUN cycle and every (divisor+1) cycles thereafter. Divisor 0 → strobe every cycle; 255 → every 256. Latched divisor and mask do not change in RUN regardless of inputs.
- RUN exits: fifo_overflow=1 → HALT, overflow_flag set; clklock=0 → HALT, lock_lost_flag set; both same cycle → both flags set.
- HALT: sample_strobe=0, capture_active=0; remains until acq_enable=0.
- acq_enable=0 in any non-IDLE state → IDLE next cycle; highest priority, but any overflow/lock-loss seen in the same cycle still sets its flag.
- Sticky flags hold through IDLE so firmware can read them after stop; cleared only by rst or the next start.

## Timing
- Reset: state=IDLE, sample_strobe=0, capture_active=0, active_channels=0, all flags 0, all counters 0.
- Minimum start latency, acq_enable rise (clklock already high) to first strobe: 1 (IDLE→WAIT_LOCK) + LOCK_STABLE + SETTLE_CYCLES cycles; default 21.
- All outputs registered; status reflects the event one cycle after it is sampled.
- Strobe of the RUN-exit cycle is suppressed: no strobe is issued in the cycle following fifo_overflow, clklock=0 or acq_enable=0.
- rst mid-operation overrides everything in the same edge.

## Configuration
- ACQ_SAMPLE_LIMIT_EN defined: adds input sample_limit [31:0]. A 32-bit strobe counter clears on entry to RUN and increments per strobe. When the count reaches sample_limit, RUN → HALT and done_flag is set; that strobe is the last one. sample_limit=0 means unlimited. Counter saturates at 0xFFFFFFFF.
- Not defined: port absent, no counter, done_flag tied 0, RUN ends only on stop/overflow/lock loss.

## Test plan
- Reset, clklock=1, divisor=3, mask=0x00FF, acq_enable=1 → first strobe 21 cycles later, then every 4 cycles; active_channels=0x00FF.
- Toggle clklock low at lock count 10 in WAIT_LOCK → counter restarts; first strobe delayed by 11 extra cycles.
- Change channel_enable to 0xFFFF and divisor to 0 during RUN → active_channels stays 0x00FF, period stays 4.
- Pulse fifo_overflow for 1 cycle in RUN → HALT, overflow_flag=1, no strobe afterwards. Then acq_enable=0 → IDLE with flag still 1. Restart → flag clears.
- acq_enable=0 and clklock=0 in the same RUN cycle → IDLE next cycle, lock_lost_flag=1.
- With ACQ_SAMPLE_LIMIT_EN, sample_limit=5, divisor=0 → exactly 5 strobes, HALT, done_flag=1. sample_limit=0 → strobes continue indefinitely.
